// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller:
// funct3 size codes, controller states and access-size helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  // Access size in bytes; the low two funct3 bits encode log2(size).
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    logic [3:0] sz;
    case (funct3[1:0])
      2'd0:    sz = 4'd1;
      2'd1:    sz = 4'd2;
      2'd2:    sz = 4'd4;
      default: sz = 4'd8;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_ctrl_load_store_align.sv
// Lane steering for the data memory: byte enables and
// shifted store data, load extension and access-error flag.
module load_store_align
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  logic              legal;
  logic              misal;
  logic [3:0]        sz;
  logic [3:0]        off4;
  logic [OFF_W+2:0]  bit_off;
  logic [NB-1:0]     be_base;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] sh;
  logic              sbit;

  // Decode legality, alignment and lane masks for the access size.
  always_comb begin
    legal   = 1'b0;
    sz      = size_bytes(funct3);
    off4    = 4'(off);
    misal   = |(off4 & (sz - 4'd1));
    bit_off = {off, 3'b000};
    unique case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_D:             legal = (DATA_W == 64);
      F3_BU, F3_HU:     legal = !we;
      F3_WU:            legal = !we && (DATA_W == 64);
      default:          legal = 1'b0;
    endcase
    err = !legal || misal;
    case (funct3[1:0])
      2'd0: begin
        be_base = NB'(8'h01);
        mask    = DATA_W'(8'hFF);
      end
      2'd1: begin
        be_base = NB'(8'h03);
        mask    = DATA_W'(16'hFFFF);
      end
      2'd2: begin
        be_base = NB'(8'h0F);
        mask    = DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        be_base = '1;
        mask    = '1;
      end
    endcase
  end

  // Steer store lanes up and load lanes down, then extend.
  always_comb begin
    be       = err ? '0 : (be_base << off);
    wdata_sh = err ? '0 : (wdata << bit_off);
    sh       = rword >> bit_off;
    case (funct3[1:0])
      2'd0:    sbit = sh[7];
      2'd1:    sbit = sh[15];
      2'd2:    sbit = sh[31];
      default: sbit = sh[DATA_W-1];
    endcase
    rdata = (sh & mask)
          | ({DATA_W{sbit & ~funct3[2]}} & ~mask);
    if (err) rdata = '0;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the MEM stage: handshake FSM,
// wait-state counter, byte-lane memory and trace outputs.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int WORDS = (2 ** ADDR_W) / NB;
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              c_we;
  logic [2:0]        c_f3;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              commit;

  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] rword;
  logic              err;

  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_wr;
  logic              r_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [DATA_W-1:0] mem [WORDS];

  // Next-state, wait counter and ready decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = (WAIT_STATES > 0) ? BUSY : RESP;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The committing access comes straight from the inputs when
  // there are no wait states, otherwise from the latched copy.
  always_comb begin
    if (state_q == BUSY) begin
      c_we    = we_q;
      c_f3    = f3_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end else begin
      c_we    = req_we;
      c_f3    = req_funct3;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
    commit = (state_d == RESP) && !reset;
    rword  = mem[c_addr[ADDR_W-1:OFF_W]];
  end

  load_store_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .we      (c_we),
    .funct3  (c_f3),
    .off     (c_addr[OFF_W-1:0]),
    .wdata   (c_wdata),
    .rword   (rword),
    .be      (be),
    .wdata_sh(wsh),
    .rdata   (ext),
    .err     (err)
  );

  // State register and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on the accept edge only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (req_valid && req_ready) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Byte-lane store on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (commit && c_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[c_addr[ADDR_W-1:OFF_W]][8*i +: 8] <= wsh[8*i +: 8];
        end
      end
    end
  end

  // Register the response and trace fields at commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (commit) begin
      r_rdata <= (c_we || err) ? '0 : ext;
      r_err   <= err;
      r_wr    <= c_we && !err;
      r_rd    <= !c_we && !err;
      r_addr  <= c_addr;
      r_wdata <= (c_we && !err) ? c_wdata : '0;
    end
  end

  // Outputs are only live during the response cycle.
  always_comb begin
    resp_valid = (state_q == RESP);
    resp_rdata = resp_valid ? r_rdata : '0;
    resp_err   = resp_valid && r_err;
    wr         = resp_valid && r_wr;
    rd         = resp_valid && r_rd;
    addr       = resp_valid ? r_addr : '0;
    wr_data    = resp_valid ? r_wdata : '0;
    rd_data    = resp_valid ? r_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: three instances with
// 0, 3 and 2 wait states, responses checked on the falling edge.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int WS_TAB [3] = '{0, 3, 2};

  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [8:0]  req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic        wr         [3];
  logic        rd         [3];
  logic [8:0]  addr       [3];
  logic [31:0] wr_data    [3];
  logic [31:0] rd_data    [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gen_dut
      dmem_ctrl #(
        .DATA_W     (32),
        .ADDR_W     (9),
        .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
      ) dut (
        .clk       (clk),
        .reset     (rst[g]),
        .req_valid (req_valid[g]),
        .req_ready (req_ready[g]),
        .req_we    (req_we[g]),
        .req_funct3(req_funct3[g]),
        .req_addr  (req_addr[g]),
        .req_wdata (req_wdata[g]),
        .resp_valid(resp_valid[g]),
        .resp_rdata(resp_rdata[g]),
        .resp_err  (resp_err[g]),
        .wr        (wr[g]),
        .rd        (rd[g]),
        .addr      (addr[g]),
        .wr_data   (wr_data[g]),
        .rd_data   (rd_data[g])
      );
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          u;
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [8:0]  a;
    logic [31:0] wd;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Pop and compare on every response pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 3; u++) begin
      if (resp_valid[u] === 1'b1) begin
        check("resp_pending", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("unit", 64'(u), 64'(e.u));
          check("latency", 64'(cyc), 64'(e.cyc));
          check("rdata", 64'(resp_rdata[u]), 64'(e.rdata));
          check("err", 64'(resp_err[u]), 64'(e.err));
          check("wr", 64'(wr[u]), 64'(e.we && !e.err));
          check("rd", 64'(rd[u]), 64'(!e.we && !e.err));
          check("addr", 64'(addr[u]), 64'(e.a));
          check("wr_data", 64'(wr_data[u]),
                64'((e.we && !e.err) ? e.wd : 32'd0));
          check("rd_data", 64'(rd_data[u]), 64'(e.rdata));
          check("ready_resp", 64'(req_ready[u]), 64'd1);
        end
      end
    end
  end

  // Called at a falling edge; returns one falling edge after accept
  // with req_valid still high so calls can run back to back.
  task automatic issue(int u, logic we, logic [2:0] f3,
                       logic [8:0] a, logic [31:0] wd,
                       logic [31:0] erd, logic eerr, bit push = 1'b1);
    exp_t e;
    int n = 0;
    req_we[u]     = we;
    req_funct3[u] = f3;
    req_addr[u]   = a;
    req_wdata[u]  = wd;
    req_valid[u]  = 1'b1;
    while (req_ready[u] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n < 40), 64'd1);
    if (push) begin
      e.u = u; e.rdata = erd; e.err = eerr; e.we = we;
      e.a = a; e.wd = wd; e.cyc = cyc + 1 + WS_TAB[u];
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(int u);
    req_valid[u] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      req_valid[u] = 1'b0;
      req_we[u] = 1'b0;
      req_funct3[u] = 3'd0;
      req_addr[u] = '0;
      req_wdata[u] = '0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("rst_ready", 64'(req_ready[u]), 64'd1);
      check("rst_valid", 64'(resp_valid[u]), 64'd0);
      check("rst_rdata", 64'(resp_rdata[u]), 64'd0);
      check("rst_err", 64'(resp_err[u]), 64'd0);
      check("rst_wr", 64'(wr[u]), 64'd0);
      check("rst_rd", 64'(rd[u]), 64'd0);
      check("rst_addr", 64'(addr[u]), 64'd0);
      check("rst_wr_data", 64'(wr_data[u]), 64'd0);
      check("rst_rd_data", 64'(rd_data[u]), 64'd0);
      rst[u] = 1'b0;
    end
    @(negedge clk);

    // Zero wait states: words, lanes, extension, errors.
    issue(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 0); idle(0);
    issue(0, 0, 3'b010, 9'h010, 32'h5555AAAA, 32'hDEADBEEF, 0); idle(0);
    issue(0, 1, 3'b000, 9'h012, 32'h12345680, 32'h0, 0); idle(0);
    issue(0, 0, 3'b010, 9'h010, 32'h0, 32'hDE80BEEF, 0); idle(0);
    issue(0, 0, 3'b000, 9'h012, 32'h0, 32'hFFFFFF80, 0); idle(0);
    issue(0, 0, 3'b100, 9'h012, 32'h0, 32'h00000080, 0); idle(0);
    issue(0, 0, 3'b001, 9'h012, 32'h0, 32'hFFFFDE80, 0); idle(0);
    issue(0, 1, 3'b010, 9'h011, 32'h11111111, 32'h0, 1); idle(0);
    issue(0, 0, 3'b010, 9'h010, 32'h0, 32'hDE80BEEF, 0); idle(0);
    issue(0, 0, 3'b011, 9'h010, 32'h0, 32'h0, 1); idle(0);
    issue(0, 0, 3'b110, 9'h010, 32'h0, 32'h0, 1); idle(0);
    issue(0, 0, 3'b111, 9'h010, 32'h0, 32'h0, 1); idle(0);
    issue(0, 1, 3'b101, 9'h014, 32'hFFFF, 32'h0, 1); idle(0);
    issue(0, 1, 3'b001, 9'h016, 32'h7777ABCD, 32'h0, 0); idle(0);
    issue(0, 0, 3'b101, 9'h016, 32'h0, 32'h0000ABCD, 0); idle(0);
    issue(0, 0, 3'b001, 9'h016, 32'h0, 32'hFFFFABCD, 0); idle(0);
    issue(0, 0, 3'b001, 9'h013, 32'h0, 32'h0, 1); idle(0);
    drain();

    // Back to back with req_valid held high.
    issue(0, 0, 3'b010, 9'h010, 32'h0, 32'hDE80BEEF, 0);
    check("b2b_ready", 64'(req_ready[0]), 64'd1);
    issue(0, 0, 3'b000, 9'h012, 32'h0, 32'hFFFFFF80, 0);
    check("b2b_ready", 64'(req_ready[0]), 64'd1);
    issue(0, 0, 3'b100, 9'h012, 32'h0, 32'h00000080, 0);
    check("b2b_ready", 64'(req_ready[0]), 64'd1);
    issue(0, 0, 3'b101, 9'h016, 32'h0, 32'h0000ABCD, 0);
    check("b2b_ready", 64'(req_ready[0]), 64'd1);
    idle(0);
    drain();

    // Three wait states; inputs scrambled while BUSY.
    issue(1, 1, 3'b010, 9'h040, 32'hA5A55A5A, 32'h0, 0);
    idle(1);
    req_we[1] = 1'b0;
    req_funct3[1] = 3'b000;
    req_addr[1] = 9'h045;
    req_wdata[1] = 32'hFFFFFFFF;
    check("busy_ready_1", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    req_we[1] = 1'b1;
    check("busy_ready_2", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    check("busy_ready_3", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    check("resp_ready", 64'(req_ready[1]), 64'd1);
    @(negedge clk);
    issue(1, 0, 3'b010, 9'h040, 32'h0, 32'hA5A55A5A, 0); idle(1);
    issue(1, 0, 3'b001, 9'h041, 32'h0, 32'h0, 1); idle(1);
    issue(1, 0, 3'b000, 9'h043, 32'h0, 32'hFFFFFFA5, 0); idle(1);
    drain();

    // Two wait states; reset during BUSY cancels the store.
    issue(2, 1, 3'b010, 9'h020, 32'hCAFEF00D, 32'h0, 0); idle(2);
    issue(2, 0, 3'b010, 9'h020, 32'h0, 32'hCAFEF00D, 0); idle(2);
    drain();
    issue(2, 1, 3'b010, 9'h020, 32'h12345678, 32'h0, 0, 1'b0);
    idle(2);
    check("pre_rst_ready", 64'(req_ready[2]), 64'd0);
    rst[2] = 1'b1;
    #1;
    check("mid_rst_ready", 64'(req_ready[2]), 64'd1);
    check("mid_rst_valid", 64'(resp_valid[2]), 64'd0);
    check("mid_rst_wr", 64'(wr[2]), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data[2]), 64'd0);
    repeat (2) @(negedge clk);
    check("hold_rst_valid", 64'(resp_valid[2]), 64'd0);
    rst[2] = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(resp_valid[2]), 64'd0);
    issue(2, 0, 3'b010, 9'h020, 32'h0, 32'hCAFEF00D, 0); idle(2);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory controller for the pipelined RISC-V core; it replaces the fixed word-only data memory behind the MEM stage.
- Supports RV32/RV64 load/store sizes with sign/zero extension, byte-lane stores, misalignment detection and a configurable wait-state count.
- A valid/ready handshake lets the pipeline stall while an access is in progress.
- Drives the same wr/rd/addr/wr_data/rd_data trace signals the core exports for the testbench.

Parameters:
- DATA_W, 32, word width; legal values 32 or 64.
- ADDR_W, 9, byte-address width; memory holds 2**ADDR_W bytes, i.e. 2**ADDR_W/(DATA_W/8) words.
- WAIT_STATES, 0, extra cycles between request accept and response; range 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM-stage access request.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: response present.
- resp_rdata  out  DATA_W  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned address or illegal funct3; qualified by resp_valid.
- wr  out  1  trace: store committed; coincident with resp_valid.
- rd  out  1  trace: load committed; coincident with resp_valid.
- addr  out  ADDR_W  trace: committed byte address.
- wr_data  out  DATA_W  trace: req_wdata of the committed store.
- rd_data  out  DATA_W  trace: equals resp_rdata on loads.

Behaviour:
- Reset (async, active-high): state IDLE, wait counter 0; req_ready=1; every other output 0. Memory contents are not reset.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid, latch the request; go to BUSY if WAIT_STATES>0, else RESP.
  - BUSY: req_ready=0. Counter loads WAIT_STATES-1 on entry and decrements each cycle; go to RESP after the cycle in which the counter is 0.
  - RESP: resp_valid=1 and req_ready=1. A new req_valid is accepted, giving back-to-back operation: next state BUSY/RESP as from IDLE. With no new request, next state is IDLE.
- Latency: request accepted at edge T gives resp_valid during cycle T+1+WAIT_STATES. With WAIT_STATES=0, throughput is one access per cycle.
- Commit point: the store write and load read both happen on the edge that enters RESP. A reset asserted before that edge cancels the access; memory is untouched.
- funct3 codes:
  - 000 B, 001 H, 010 W, 011 D (legal only when DATA_W=64), 100 BU, 101 HU, 110 WU (legal only when DATA_W=64).
  - Stores accept only the signed codes B/H/W/D.
  - Any other code sets resp_err=1.
- Alignment: an access is misaligned if the byte address is not a multiple of its size. A misaligned access sets resp_err=1, performs no write, and forces rdata and the wr/rd trace bits to 0.
- Stores: only the addressed byte lanes are written; the data comes from the low bits of req_wdata. Other lanes are preserved.
- Loads: the selected lanes are shifted to bit 0, then sign-extended (signed codes) or zero-extended (U codes) to DATA_W.
- Address wrap: none needed; ADDR_W bits cover the whole array exactly.
- req_* inputs are sampled only on the accept edge; changes while BUSY are ignored.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams (F3_B..F3_WU);
  - the state enum {IDLE, BUSY, RESP};
  - a function size_bytes(funct3).
- Sub-module load_store_align (combinational), generating:
  - byte-enable mask and shifted store data from {funct3, addr offset, wdata};
  - extended load data from {funct3, offset, raw word};
  - the err flag.
- dmem_ctrl contains the FSM, counter, memory array and trace registers.

Test Plan:
- Word store/load, WAIT_STATES=0: SW 0xDEADBEEF at 0x010, then LW 0x010. Required: resp_valid exactly 1 cycle after each accept, resp_rdata=0xDEADBEEF, wr=1 on the store response, rd=1 on the load response.
- Byte lanes and extension: after the SW above, SB 0x80 at 0x012, then:
  - LW 0x010 returns 0xDE80BEEF;
  - LB 0x012 returns 0xFFFFFF80;
  - LBU 0x012 returns 0x00000080;
  - LH 0x012 returns 0xFFFFDE80.
- Misalignment and illegal codes: SW at 0x011 gives resp_err=1, wr=0, and a following LW 0x010 shows memory unchanged. funct3=011 with DATA_W=32 gives resp_err=1.
- Wait states, WAIT_STATES=3: accept at edge T gives resp_valid in cycle T+4, req_ready=0 in cycles T+1..T+3, and inputs toggled during BUSY have no effect.
- Back-to-back, WAIT_STATES=0: req_valid held high for 4 consecutive loads gives 4 consecutive resp_valid pulses with correct data and req_ready never low.
- Reset mid-operation, WAIT_STATES=2: SW 0x12345678 at 0x020 with reset pulsed during BUSY. Required: all outputs 0 immediately; the state returns to IDLE; a later LW 0x020 returns the pre-existing value, i.e. the store was cancelled.
